// File: rtl/multdiv.sv
// rtl/multdiv.sv - iterative signed multiply/divide unit beside the execute-stage ALU
//
// Purpose:
//   Runs a signed WIDTH-bit multiply (shift-add) or divide (restoring) over WIDTH
//   iterations. One shared WIDTH+1-bit adder/subtractor serves both operations.
//   Both operations work on operand magnitudes, and the sign is fixed in DONE.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high; aborts any operation in flight
//   data_operandA  multiplicand / dividend, sampled on the start edge
//   data_operandB  multiplier / divisor, sampled on the start edge
//   ctrl_MULT      start pulse for A*B (wins if ctrl_DIV is also high)
//   ctrl_DIV       start pulse for A/B
//   data_result    low product word or quotient, held between operations
//   data_exception overflow / divide-by-zero, held between operations
//   data_resultRDY one-cycle completion strobe

module multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_next;

  logic             start, start_div;
  logic             load, step, finish;
  logic [CW-1:0]    count;
  logic             op_div, neg, div_zero;
  // hi:lo is the product (mult) or remainder:quotient (div); m is the fixed addend
  logic [WIDTH-1:0] hi, lo, m;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   add_a, add_b, add_sum, mul_sum;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0] quot_signed;
  logic [WIDTH-1:0] fix_result;
  logic             fix_exc;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;

  // Magnitudes stay unsigned WIDTH bits, so -2^(WIDTH-1) becomes 2^(WIDTH-1) exactly
  assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Shared adder: mult adds m to the upper half. Div subtracts m from the
  // remainder shifted left with the next dividend bit.
  always_comb begin
    add_a   = op_div ? {hi, lo[WIDTH-1]} : {1'b0, hi};
    add_b   = op_div ? ~{1'b0, m} : {1'b0, m};
    add_sum = add_a + add_b + (WIDTH+1)'(op_div);
    mul_sum = lo[0] ? add_sum : {1'b0, hi};
  end

  // Sign fix and exception evaluation, consumed only in DONE
  always_comb begin
    prod_signed = neg ? -{hi, lo} : {hi, lo};
    quot_signed = neg ? -lo : lo;
    fix_result  = '0;
    fix_exc     = 1'b0;
    if (op_div) begin
      if (div_zero) begin
        fix_result = '0;
        fix_exc    = 1'b1;
      end else begin
        fix_result = quot_signed;
        // a positive quotient of 2^(WIDTH-1) only arises from -2^(WIDTH-1) / -1
        fix_exc    = ~neg & lo[WIDTH-1];
      end
    end else begin
      fix_result = prod_signed[WIDTH-1:0];
      fix_exc    = ~((&prod_signed[2*WIDTH-1:WIDTH-1]) | ~(|prod_signed[2*WIDTH-1:WIDTH-1]));
    end
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM: next state (a start pulse restarts from any state)
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = BUSY;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        BUSY:    state_next = (count == CW'(WIDTH-1)) ? DONE : BUSY;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM: control outputs
  always_comb begin
    load   = start;
    step   = (state == BUSY) & ~start;
    finish = (state == DONE) & ~start;
  end

  // Datapath and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      count          <= '0;
      op_div         <= 1'b0;
      neg            <= 1'b0;
      div_zero       <= 1'b0;
      hi             <= '0;
      lo             <= '0;
      m              <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (load) begin
        count    <= '0;
        op_div   <= start_div;
        neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= start_div & (data_operandB == '0);
        hi       <= '0;
        lo       <= start_div ? abs_a : abs_b;
        m        <= start_div ? abs_b : abs_a;
      end else if (step) begin
        count <= count + CW'(1);
        if (op_div) begin
          if (!add_sum[WIDTH]) begin
            hi <= add_sum[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], 1'b1};
          end else begin
            hi <= add_a[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], 1'b0};
          end
        end else begin
          hi <= mul_sum[WIDTH:1];
          lo <= {mul_sum[0], lo[WIDTH-1:1]};
        end
      end else if (finish) begin
        data_result    <= fix_result;
        data_exception <= fix_exc;
        data_resultRDY <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// tb/tb_multdiv.sv - scoreboard bench for multdiv

module tb_multdiv;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  multdiv #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pops and compares on every completion strobe
  always @(negedge clock) begin
    if (data_resultRDY) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rdy cycle=%0d result=%h", cyc, data_result);
      end else begin
        e = sb.pop_front();
        checks++;
        if (data_result !== e.res) begin
          failures++;
          $display("FAIL %s_result got=%h exp=%h", e.name, data_result, e.res);
        end
        checks++;
        if (data_exception !== e.exc) begin
          failures++;
          $display("FAIL %s_exception got=%b exp=%b", e.name, data_exception, e.exc);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL %s_latency got_cycle=%0d exp_cycle=%0d", e.name, cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drives a one-cycle start; expected RDY lands 34 edges after the drive point
  task automatic issue(input string name, input logic mul, input logic dv,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic exc, input logic expect_rdy);
    exp_t x;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mul;
    ctrl_DIV      = dv;
    if (expect_rdy) begin
      x.name = name;
      x.res  = res;
      x.exc  = exc;
      x.cyc  = cyc + 34;
      sb.push_back(x);
    end
    tick(1);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h1234_5678;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick(1);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d exp=0", name, sb.size());
      sb.delete();
    end
    tick(2);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      failures++;
      $display("FAIL %s got=%h/%b/%b exp=00000000/0/0", name, data_result, data_exception,
               data_resultRDY);
    end
  endtask

  initial begin
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    tick(3);
    check_zero("reset_state");
    reset = 1'b0;
    tick(1);

    issue("mul_7_m6",     1, 0, 32'd7,        32'hFFFF_FFFA, 32'hFFFF_FFD6, 0, 1); drain("mul_7_m6");
    issue("mul_ovf",      1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0,        1, 1); drain("mul_ovf");
    issue("mul_min_1",    1, 0, 32'h8000_0000, 32'd1,        32'h8000_0000, 0, 1); drain("mul_min_1");
    issue("mul_m3_m5",    1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd15,       0, 1); drain("mul_m3_m5");
    issue("mul_max_2",    1, 0, 32'h7FFF_FFFF, 32'd2,        32'hFFFF_FFFE, 1, 1); drain("mul_max_2");
    issue("div_m7_2",     0, 1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 0, 1); drain("div_m7_2");
    issue("div_100_0",    0, 1, 32'd100,       32'd0,        32'h0,         1, 1); drain("div_100_0");
    issue("div_100_m7",   0, 1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, 1); drain("div_100_m7");
    issue("div_min_m1",   0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1); drain("div_min_m1");
    issue("div_min_1",    0, 1, 32'h8000_0000, 32'd1,        32'h8000_0000, 0, 1); drain("div_min_1");

    // Abort: divide restarted as a multiply ten cycles in; only the multiply completes
    issue("div_aborted",  0, 1, 32'd50, 32'd5, 32'd10, 0, 0);
    tick(9);
    issue("mul_restart",  1, 0, 32'd3,  32'd4, 32'd12, 0, 1);
    drain("mul_restart");

    // Reset in the middle of a busy operation clears outputs; no RDY follows
    issue("mul_reset",    1, 0, 32'd9,  32'd9, 32'd81, 0, 0);
    tick(10);
    reset = 1'b1;
    tick(1);
    check_zero("reset_mid_busy");
    reset = 1'b0;
    tick(45);

    issue("mul_and_div",  1, 1, 32'd6,  32'd3, 32'd18, 0, 1); drain("mul_and_div");

    tick(5);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty pending=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
